// File: rtl/facto_host_sequencer.sv
// facto_host_sequencer
//   Bus-master front end for the factorial core. Takes an operand on a
//   valid/ready request port, programs the core (operand, intrEn, opstart),
//   waits for completion (interrupt or opdone polling), reads the 128-bit
//   result, clears the core and returns the result on a valid/ready response.
// Ports
//   clk, reset_n                     clock / async active-low reset
//   req_valid, req_ready, req_operand request channel (64-bit operand)
//   rsp_valid, rsp_ready, rsp_result, rsp_timeout  response channel
//   m_sel, m_wr, m_addr, m_wdata, m_rdata          core register bus
//   intr                             core interrupt (level)
//   busy                             high whenever not IDLE
module facto_host_sequencer #(
  parameter logic [15:0] BASE_ADDR = 16'h7000,
  parameter int          READ_LAT  = 1,
  parameter int          USE_INTR  = 1,
  parameter int          TIMEOUT   = 4096
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [63:0]  req_operand,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_result,
  output logic         rsp_timeout,
  output logic         m_sel,
  output logic         m_wr,
  output logic [15:0]  m_addr,
  output logic [63:0]  m_wdata,
  input  logic [63:0]  m_rdata,
  input  logic         intr,
  output logic         busy
);

  localparam logic [15:0] A_START = BASE_ADDR + 16'h00;
  localparam logic [15:0] A_CLEAR = BASE_ADDR + 16'h08;
  localparam logic [15:0] A_DONE  = BASE_ADDR + 16'h10;
  localparam logic [15:0] A_IEN   = BASE_ADDR + 16'h18;
  localparam logic [15:0] A_OPND  = BASE_ADDR + 16'h20;
  localparam logic [15:0] A_RESH  = BASE_ADDR + 16'h28;
  localparam logic [15:0] A_RESL  = BASE_ADDR + 16'h30;
  localparam int          WCW     = $clog2(TIMEOUT);
  localparam logic        POLL    = (USE_INTR == 0);

  typedef enum logic [3:0] {
    IDLE, WR_OPND, WR_IEN, WR_START, WAIT, RD_H, RD_L, CLR1, CLR0, RESP
  } state_t;

  state_t           state, state_nxt;
  logic [63:0]      opnd;
  logic [1:0]       lat_cnt;
  logic [WCW-1:0]   wcnt;
  logic             rd_state, rd_last, done_now, wait_expired;

  // A read is in flight in RD_H/RD_L, and in WAIT while polling opdone.
  assign rd_state     = (state == RD_H) || (state == RD_L) || ((state == WAIT) && POLL);
  assign rd_last      = rd_state && (lat_cnt == 2'(READ_LAT - 1));
  assign done_now     = POLL ? (rd_last && m_rdata[0]) : intr;
  assign wait_expired = (wcnt == WCW'(TIMEOUT - 1));

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (req_valid) state_nxt = WR_OPND;
      WR_OPND:  state_nxt = WR_IEN;
      WR_IEN:   state_nxt = WR_START;
      WR_START: state_nxt = WAIT;
      // done has priority over an expiring wait counter
      WAIT:     if (done_now)          state_nxt = RD_H;
                else if (wait_expired) state_nxt = CLR1;
      RD_H:     if (rd_last) state_nxt = RD_L;
      RD_L:     if (rd_last) state_nxt = CLR1;
      CLR1:     state_nxt = CLR0;
      CLR0:     state_nxt = RESP;
      RESP:     if (rsp_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // bus and handshake outputs, decoded straight from state
  always_comb begin
    m_sel   = 1'b0;
    m_wr    = 1'b0;
    m_addr  = 16'h0;
    m_wdata = 64'h0;
    case (state)
      WR_OPND:  begin m_sel = 1'b1; m_wr = 1'b1; m_addr = A_OPND;  m_wdata = opnd; end
      WR_IEN:   begin m_sel = 1'b1; m_wr = 1'b1; m_addr = A_IEN;   m_wdata = POLL ? 64'd0 : 64'd1; end
      WR_START: begin m_sel = 1'b1; m_wr = 1'b1; m_addr = A_START; m_wdata = 64'd1; end
      WAIT:     if (POLL) begin m_sel = 1'b1; m_addr = A_DONE; end
      RD_H:     begin m_sel = 1'b1; m_addr = A_RESH; end
      RD_L:     begin m_sel = 1'b1; m_addr = A_RESL; end
      CLR1:     begin m_sel = 1'b1; m_wr = 1'b1; m_addr = A_CLEAR; m_wdata = 64'd1; end
      CLR0:     begin m_sel = 1'b1; m_wr = 1'b1; m_addr = A_CLEAR; m_wdata = 64'd0; end
      default:  ;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  // datapath: operand latch, read latency counter, wait counter, result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opnd        <= '0;
      lat_cnt     <= '0;
      wcnt        <= '0;
      rsp_result  <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      lat_cnt <= (rd_state && !rd_last) ? lat_cnt + 2'd1 : 2'd0;
      case (state)
        IDLE: if (req_valid) begin
          opnd        <= req_operand;
          rsp_result  <= '0;      // a timed-out job reports zero
          rsp_timeout <= 1'b0;
        end
        WR_START: wcnt <= '0;
        WAIT: begin
          wcnt <= wcnt + WCW'(1);
          if (!done_now && wait_expired) rsp_timeout <= 1'b1;
        end
        RD_H: if (rd_last) rsp_result[127:64] <= m_rdata;
        RD_L: if (rd_last) rsp_result[63:0]   <= m_rdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_facto_host_sequencer.sv
// Bench for facto_host_sequencer. Two instances share the clock/reset:
// u0 waits on intr (READ_LAT=1), u1 polls opdone (READ_LAT=2); both use
// TIMEOUT=64. Each has its own behavioural factorial core on the bus.
module tb_facto_host_sequencer;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic [1:0]            req_valid = '0, req_ready, rsp_valid, rsp_ready = '0, rsp_timeout;
  logic [1:0][63:0]      req_operand = '0;
  logic [1:0][127:0]     rsp_result;
  logic [1:0]            m_sel, m_wr, intr, busy;
  logic [1:0][15:0]      m_addr;
  logic [1:0][63:0]      m_wdata, m_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  facto_host_sequencer #(.USE_INTR(1), .READ_LAT(1), .TIMEOUT(64)) u0 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_operand(req_operand[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_result(rsp_result[0]),
    .rsp_timeout(rsp_timeout[0]), .m_sel(m_sel[0]), .m_wr(m_wr[0]), .m_addr(m_addr[0]),
    .m_wdata(m_wdata[0]), .m_rdata(m_rdata[0]), .intr(intr[0]), .busy(busy[0]));

  facto_host_sequencer #(.USE_INTR(0), .READ_LAT(2), .TIMEOUT(64)) u1 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_operand(req_operand[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_result(rsp_result[1]),
    .rsp_timeout(rsp_timeout[1]), .m_sel(m_sel[1]), .m_wr(m_wr[1]), .m_addr(m_addr[1]),
    .m_wdata(m_wdata[1]), .m_rdata(m_rdata[1]), .intr(intr[1]), .busy(busy[1]));

  // ---------------- behavioural factorial core + bus monitor ----------------
  typedef struct { logic [15:0] a; logic [63:0] d; int c; } wr_t;
  wr_t wlog0[$], wlog1[$];

  logic [1:0][63:0]  c_opnd = '0;
  logic [1:0]        c_ien = '0, c_done = '0;
  logic [1:0][127:0] c_res = '0;
  int                c_busy [2] = '{0, 0};
  int                dly [2] = '{0, 5};          // 0 = done on the opstart edge
  bit                never_done [2] = '{0, 0};
  int                rd_h_cnt [2] = '{0, 0};
  int                rd_l_cnt [2] = '{0, 0};
  int                rd_done_cnt [2] = '{0, 0};
  int                cyc = 0;

  function automatic logic [127:0] fact(input logic [63:0] n);
    logic [127:0] r = 128'd1;
    for (int i = 1; i <= int'(n); i++) r = r * 128'(i);
    return r;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (c_busy[k] != 0) begin
        c_busy[k] <= c_busy[k] - 1;
        if (c_busy[k] == 1 && !never_done[k]) begin
          c_done[k] <= 1'b1;
          c_res[k]  <= fact(c_opnd[k]);
        end
      end
      if (m_sel[k] && m_wr[k]) begin
        wr_t e;
        e.a = m_addr[k]; e.d = m_wdata[k]; e.c = cyc;
        if (k == 0) wlog0.push_back(e); else wlog1.push_back(e);
        case (m_addr[k])
          16'h7020: c_opnd[k] <= m_wdata[k];
          16'h7018: c_ien[k]  <= m_wdata[k][0];
          16'h7000: if (m_wdata[k][0]) begin
            c_done[k] <= 1'b0;
            if (never_done[k]) c_busy[k] <= 0;
            else if (dly[k] == 0) begin c_done[k] <= 1'b1; c_res[k] <= fact(c_opnd[k]); end
            else c_busy[k] <= dly[k];
          end
          16'h7008: if (m_wdata[k][0]) c_done[k] <= 1'b0;
          default: ;
        endcase
      end
      if (m_sel[k] && !m_wr[k]) begin
        if (m_addr[k] == 16'h7028) rd_h_cnt[k]    <= rd_h_cnt[k] + 1;
        if (m_addr[k] == 16'h7030) rd_l_cnt[k]    <= rd_l_cnt[k] + 1;
        if (m_addr[k] == 16'h7010) rd_done_cnt[k] <= rd_done_cnt[k] + 1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      intr[k]    = c_done[k] & c_ien[k];
      m_rdata[k] = 64'h0;
      case (m_addr[k])
        16'h7010: m_rdata[k] = {63'h0, c_done[k]};
        16'h7028: m_rdata[k] = c_res[k][127:64];
        16'h7030: m_rdata[k] = c_res[k][63:0];
        default:  m_rdata[k] = 64'h0;
      endcase
    end
  end

  // ---------------- stimulus helpers (no checking inside) ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic accept(input int k, input logic [63:0] op);
    int n = 0;
    req_valid[k] = 1'b1; req_operand[k] = op;
    while (!req_ready[k] && n < 1000) begin tick(); n++; end
    tick();
    req_valid[k] = 1'b0;
  endtask

  task automatic wait_rsp(input int k, input int max, output int n);
    n = 0;
    while (!rsp_valid[k] && n < max) begin tick(); n++; end
  endtask

  task automatic consume(input int k);
    rsp_ready[k] = 1'b1; tick(); rsp_ready[k] = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      checks++; if (req_ready[k] !== 1'b1) begin errors++; $display("FAIL reset_req_ready[%0d] got %b exp 1", k, req_ready[k]); end
      checks++; if (busy[k] !== 1'b0 || rsp_valid[k] !== 1'b0 || rsp_timeout[k] !== 1'b0) begin
        errors++; $display("FAIL reset_flags[%0d] busy %b rsp_valid %b rsp_timeout %b exp 0", k, busy[k], rsp_valid[k], rsp_timeout[k]); end
      checks++; if (m_sel[k] !== 1'b0 || m_wr[k] !== 1'b0 || m_addr[k] !== 16'h0 || m_wdata[k] !== 64'h0) begin
        errors++; $display("FAIL reset_bus[%0d] sel %b wr %b addr %h wdata %h exp 0", k, m_sel[k], m_wr[k], m_addr[k], m_wdata[k]); end
      checks++; if (rsp_result[k] !== 128'h0) begin errors++; $display("FAIL reset_result[%0d] got %h exp 0", k, rsp_result[k]); end
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_intr_op0();
    int wb = wlog0.size(), hb = rd_h_cnt[0], lb = rd_l_cnt[0], lat;
    logic [15:0] ea [5] = '{16'h7020, 16'h7018, 16'h7000, 16'h7008, 16'h7008};
    logic [63:0] ed [5] = '{64'd0, 64'd1, 64'd1, 64'd1, 64'd0};
    accept(0, 64'd0);
    wait_rsp(0, 200, lat);
    checks++; if (lat != 8) begin errors++; $display("FAIL op0_latency got %0d exp 8", lat); end
    checks++; if (rsp_result[0] !== 128'd1 || rsp_timeout[0] !== 1'b0) begin
      errors++; $display("FAIL op0_result got %h/%b exp 1/0", rsp_result[0], rsp_timeout[0]); end
    checks++; if (wlog0.size() != wb + 5) begin errors++; $display("FAIL op0_write_count got %0d exp 5", wlog0.size() - wb); end
    else for (int i = 0; i < 5; i++) begin
      checks++; if (wlog0[wb+i].a !== ea[i] || wlog0[wb+i].d !== ed[i]) begin
        errors++; $display("FAIL op0_write%0d got %h<-%h exp %h<-%h", i, wlog0[wb+i].a, wlog0[wb+i].d, ea[i], ed[i]); end
    end
    checks++; if (rd_h_cnt[0] - hb != 1 || rd_l_cnt[0] - lb != 1) begin
      errors++; $display("FAIL op0_reads got h %0d l %0d exp 1 1", rd_h_cnt[0] - hb, rd_l_cnt[0] - lb); end
    consume(0);
    checks++; if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
      errors++; $display("FAIL op0_release got rsp_valid %b req_ready %b exp 0 1", rsp_valid[0], req_ready[0]); end
  endtask

  task automatic test_back_to_back();
    int lat;
    rsp_ready[0] = 1'b1;
    req_valid[0] = 1'b1; req_operand[0] = 64'd12;
    tick();                                   // handshake for 12
    req_operand[0] = 64'd20;                  // held valid while busy: ignored
    wait_rsp(0, 200, lat);
    checks++; if (rsp_result[0] !== 128'h1C8CFC00) begin errors++; $display("FAIL b2b_first got %h exp 1c8cfc00", rsp_result[0]); end
    tick();                                   // response handshake
    checks++; if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0) begin
      errors++; $display("FAIL b2b_ready got req_ready %b rsp_valid %b exp 1 0", req_ready[0], rsp_valid[0]); end
    tick();                                   // handshake for 20
    req_valid[0] = 1'b0;
    checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL b2b_second_accept got busy %b exp 1", busy[0]); end
    wait_rsp(0, 200, lat);
    checks++; if (rsp_result[0] !== 128'h21C3677C82B40000) begin errors++; $display("FAIL b2b_second got %h exp 21c3677c82b40000", rsp_result[0]); end
    tick();
    rsp_ready[0] = 1'b0;
  endtask

  task automatic test_poll();
    int wb = wlog1.size(), db = rd_done_cnt[1], hb = rd_h_cnt[1], lat;
    accept(1, 64'd12);
    wait_rsp(1, 300, lat);
    checks++; if (rsp_valid[1] !== 1'b1 || rsp_result[1] !== 128'd479001600 || rsp_timeout[1] !== 1'b0) begin
      errors++; $display("FAIL poll_result got v %b %0d to %b exp 1 479001600 0", rsp_valid[1], rsp_result[1], rsp_timeout[1]); end
    checks++; if (wlog1.size() < wb + 2 || wlog1[wb+1].a !== 16'h7018 || wlog1[wb+1].d !== 64'd0) begin
      errors++; $display("FAIL poll_intren got size %0d exp intrEn<-0", wlog1.size() - wb); end
    checks++; if (rd_done_cnt[1] - db < 4) begin errors++; $display("FAIL poll_reads got %0d opdone cycles exp >=4", rd_done_cnt[1] - db); end
    checks++; if (rd_h_cnt[1] - hb != 2) begin errors++; $display("FAIL poll_rdh_len got %0d exp 2", rd_h_cnt[1] - hb); end
    consume(1);
  endtask

  task automatic test_timeout();
    int wb = wlog0.size(), hb = rd_h_cnt[0], lb = rd_l_cnt[0], lat;
    never_done[0] = 1'b1;
    accept(0, 64'd7);
    wait_rsp(0, 300, lat);
    checks++; if (lat != 69) begin errors++; $display("FAIL to_latency got %0d exp 69", lat); end
    checks++; if (rsp_timeout[0] !== 1'b1 || rsp_result[0] !== 128'h0) begin
      errors++; $display("FAIL to_response got to %b result %h exp 1 0", rsp_timeout[0], rsp_result[0]); end
    checks++; if (rd_h_cnt[0] != hb || rd_l_cnt[0] != lb) begin errors++; $display("FAIL to_no_reads got h %0d l %0d exp 0 0", rd_h_cnt[0] - hb, rd_l_cnt[0] - lb); end
    checks++; if (wlog0.size() != wb + 5) begin errors++; $display("FAIL to_write_count got %0d exp 5", wlog0.size() - wb); end
    else begin
      checks++; if (wlog0[wb+3].a !== 16'h7008 || wlog0[wb+3].d !== 64'd1 || wlog0[wb+4].a !== 16'h7008 || wlog0[wb+4].d !== 64'd0) begin
        errors++; $display("FAIL to_opclear got %h<-%h %h<-%h exp 7008<-1 7008<-0", wlog0[wb+3].a, wlog0[wb+3].d, wlog0[wb+4].a, wlog0[wb+4].d); end
      checks++; if (wlog0[wb+3].c - wlog0[wb+2].c != 65) begin
        errors++; $display("FAIL to_wait_len got %0d exp 65", wlog0[wb+3].c - wlog0[wb+2].c); end
    end
    consume(0);
    never_done[0] = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat, bad = 0;
    accept(0, 64'd3);
    wait_rsp(0, 200, lat);
    req_valid[0] = 1'b1; req_operand[0] = 64'd4;
    for (int i = 0; i < 20; i++) begin
      checks++; if (rsp_valid[0] !== 1'b1 || rsp_result[0] !== 128'd6 || rsp_timeout[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
        errors++; $display("FAIL bp_hold cycle %0d got v %b res %0d to %b rdy %b exp 1 6 0 0", i, rsp_valid[0], rsp_result[0], rsp_timeout[0], req_ready[0]); end
      tick();
    end
    consume(0);
    checks++; if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL bp_after got req_ready %b exp 1", req_ready[0]); end
    tick();
    req_valid[0] = 1'b0;
    wait_rsp(0, 200, lat);
    checks++; if (rsp_result[0] !== 128'd24) begin errors++; $display("FAIL bp_next got %0d exp 24", rsp_result[0]); end
    consume(0);
  endtask

  task automatic test_reset_mid();
    int wb, lat;
    never_done[0] = 1'b1;
    accept(0, 64'd9);
    repeat (10) tick();
    checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", busy[0]); end
    wb = wlog0.size();
    reset_n = 1'b0;
    #1;
    checks++; if (busy[0] !== 1'b0 || req_ready[0] !== 1'b1 || m_sel[0] !== 1'b0 || rsp_valid[0] !== 1'b0) begin
      errors++; $display("FAIL mid_async got busy %b rdy %b sel %b v %b exp 0 1 0 0", busy[0], req_ready[0], m_sel[0], rsp_valid[0]); end
    repeat (2) tick();
    reset_n = 1'b1;
    never_done[0] = 1'b0;
    repeat (5) tick();
    checks++; if (rsp_valid[0] !== 1'b0 || wlog0.size() != wb) begin
      errors++; $display("FAIL mid_no_rsp got v %b writes %0d exp 0 0", rsp_valid[0], wlog0.size() - wb); end
    accept(0, 64'd5);
    wait_rsp(0, 200, lat);
    checks++; if (rsp_valid[0] !== 1'b1 || rsp_result[0] !== 128'd120) begin
      errors++; $display("FAIL mid_next got v %b %0d exp 1 120", rsp_valid[0], rsp_result[0]); end
    consume(0);
  endtask

  initial begin
    test_reset();
    test_intr_op0();
    test_back_to_back();
    test_poll();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
